// File: rtl/fcs_append.sv
// Ethernet FCS generator for a 2-bit RMII transmit datapath: forwards the body
// with one cycle of latency, zero-pads it to MIN_BYTES, appends the CRC-32, then holds off for the IFG.
module fcs_append #(
    parameter int MIN_BYTES  = 60,
    parameter int IFG_CYCLES = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiir,
    output logic       axiov,
    output logic [1:0] axiod
);

    localparam int LIMIT_I = 4 * MIN_BYTES;
    localparam int CW      = (LIMIT_I > 1) ? $clog2(LIMIT_I + 1) : 1;
    localparam int IW      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT    = CW'(LIMIT_I);
    localparam logic [IW-1:0] IFG_LAST = IW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, IFG} state_t;

    state_t        state_q, state_d;
    logic [31:0]   crc_q, crc_d;
    logic [31:0]   fcs_q, fcs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    k_q, k_d;
    logic [IW-1:0] ifg_q, ifg_d;
    logic          ov_q, ov_d;
    logic [1:0]    od_q, od_d;
    logic          pad_more;
    logic [CW-1:0] cnt_inc;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // The dibit count saturates at LIMIT, so inequality means "still below minimum".
    assign pad_more = (cnt_q != LIMIT);
    assign cnt_inc  = pad_more ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            crc_q   <= '1;
            fcs_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            ifg_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            fcs_q   <= fcs_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            ifg_q   <= ifg_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (axiiv) state_d = DATA;
            DATA: if (!axiiv) state_d = pad_more ? PAD : FCS;
            PAD:  if (!pad_more) state_d = FCS;
            FCS:  if (k_q == 4'd15) state_d = (IFG_CYCLES == 0) ? IDLE : IFG;
            IFG:  if (ifg_q == IFG_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output register is loaded with the dibit belonging to the next state, so
    // body, pad and FCS leave back to back with no bubble.
    always_comb begin
        crc_d = crc_q;
        fcs_d = fcs_q;
        cnt_d = cnt_q;
        k_d   = k_q;
        ifg_d = ifg_q;
        ov_d  = 1'b0;
        od_d  = '0;
        unique case (state_q)
            IDLE: begin
                crc_d = '1;
                cnt_d = '0;
                k_d   = '0;
                ifg_d = '0;
                if (axiiv) begin
                    ov_d  = 1'b1;
                    od_d  = axiid;
                    crc_d = crc_dibit(crc_q, axiid);
                    cnt_d = cnt_inc;
                end
            end
            DATA, PAD: begin
                ov_d = 1'b1;
                if (state_q == DATA && axiiv) begin
                    od_d  = axiid;
                    crc_d = crc_dibit(crc_q, axiid);
                    cnt_d = cnt_inc;
                end else if (pad_more) begin
                    od_d  = '0;
                    crc_d = crc_dibit(crc_q, 2'b00);
                    cnt_d = cnt_inc;
                end else begin
                    fcs_d = ~crc_q;
                    od_d  = ~crc_q[1:0];
                    k_d   = 4'd1;
                end
            end
            FCS: begin
                ov_d  = 1'b1;
                od_d  = fcs_q[{k_q, 1'b0} +: 2];
                k_d   = k_q + 4'd1;
                crc_d = '1;
                cnt_d = '0;
                ifg_d = '0;
            end
            IFG: begin
                ifg_d = ifg_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign axiir = (state_q == IDLE) || (state_q == DATA);
    assign axiov = ov_q;
    assign axiod = od_q;

endmodule

// File: tb/tb_fcs_append.sv
// Directed bench for fcs_append: one unpadded instance (MIN_BYTES=0) and one
// default instance, checked against known CRC values and a reference CRC model.
module tb_fcs_append;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_v, a_r, a_ov;
    logic [1:0] a_d, a_od;
    logic       b_v, b_r, b_ov;
    logic [1:0] b_d, b_od;

    fcs_append #(.MIN_BYTES(0), .IFG_CYCLES(48)) u_a (
        .clk(clk), .rst(rst), .axiiv(a_v), .axiid(a_d),
        .axiir(a_r), .axiov(a_ov), .axiod(a_od)
    );

    fcs_append #(.MIN_BYTES(60), .IFG_CYCLES(48)) u_b (
        .clk(clk), .rst(rst), .axiiv(b_v), .axiid(b_d),
        .axiir(b_r), .axiov(b_ov), .axiod(b_od)
    );

    int errors = 0;
    int checks = 0;

    logic       lv[$];
    logic [1:0] ld[$];
    logic       lr[$];
    logic       ref_v[$];
    logic [1:0] ref_d[$];
    logic [1:0] body[$];

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] expected_fcs(input int min_bytes);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < body.size(); i++) c = crc_dibit(c, body[i]);
        for (int i = body.size(); i < 4 * min_bytes; i++) c = crc_dibit(c, 2'b00);
        return ~c;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int j = 0; j < 4; j++) body.push_back(b[2*j +: 2]);
    endtask

    task automatic load_check_string();
        logic [7:0] s [9];
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        body.delete();
        for (int i = 0; i < 9; i++) push_byte(s[i]);
    endtask

    task automatic load_pattern(input int nbytes, input int seed);
        body.delete();
        for (int i = 0; i < nbytes; i++) push_byte(8'((i * 37 + seed) & 255));
    endtask

    task automatic clear_log();
        lv.delete();
        ld.delete();
        lr.delete();
    endtask

    task automatic cycle(input int sel, input logic v, input logic [1:0] d);
        @(posedge clk);
        #1;
        if (sel == 0) begin a_v = v; a_d = d; end
        else          begin b_v = v; b_d = d; end
        @(negedge clk);
        if (sel == 0) begin lv.push_back(a_ov); ld.push_back(a_od); lr.push_back(a_r); end
        else          begin lv.push_back(b_ov); ld.push_back(b_od); lr.push_back(b_r); end
    endtask

    task automatic send_frame(input int sel, input int tail);
        for (int i = 0; i < body.size(); i++) cycle(sel, 1'b1, body[i]);
        for (int i = 0; i < tail; i++) cycle(sel, 1'b0, 2'b00);
    endtask

    task automatic find_run(input int from, output int start, output int len);
        start = -1;
        len   = 0;
        for (int i = from; i < lv.size(); i++) begin
            if (lv[i] === 1'b1) begin
                if (start < 0) start = i;
                len++;
            end else if (start >= 0) begin
                break;
            end
        end
    endtask

    task automatic get_fcs(input int pos, output logic [31:0] f);
        f = '0;
        for (int k = 0; k < 16; k++)
            if (pos + k >= 0 && pos + k < ld.size()) f[2*k +: 2] = ld[pos + k];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_v = 1'b0; a_d = '0;
        b_v = 1'b0; b_d = '0;
        #3;
        checks++; if (a_ov !== 1'b0)  begin errors++; $display("FAIL reset_a_axiov got %b want 0", a_ov); end
        checks++; if (a_od !== 2'b00) begin errors++; $display("FAIL reset_a_axiod got %b want 00", a_od); end
        checks++; if (a_r !== 1'b1)   begin errors++; $display("FAIL reset_a_axiir got %b want 1", a_r); end
        checks++; if (b_ov !== 1'b0)  begin errors++; $display("FAIL reset_b_axiov got %b want 0", b_ov); end
        checks++; if (b_r !== 1'b1)   begin errors++; $display("FAIL reset_b_axiir got %b want 1", b_r); end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (b_ov !== 1'b0 || b_r !== 1'b1)
            begin errors++; $display("FAIL idle_after_reset got ov=%b r=%b want ov=0 r=1", b_ov, b_r); end
    endtask

    task automatic test_crc_min0();
        int s, n, bad, f_end;
        logic [31:0] f;
        clear_log();
        load_check_string();
        send_frame(0, 80);
        find_run(0, s, n);
        checks++; if (s !== 1)  begin errors++; $display("FAIL min0_latency got start=%0d want 1", s); end
        checks++; if (n !== 52) begin errors++; $display("FAIL min0_length got %0d want 52", n); end
        bad = 0;
        for (int i = 0; i < 36; i++) if (ld[1 + i] !== body[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL min0_echo got %0d bad dibits want 0", bad); end
        get_fcs(37, f);
        checks++; if (f !== 32'hCBF43926) begin errors++; $display("FAIL min0_fcs got %h want cbf43926", f); end
        checks++; if (lr[36] !== 1'b1 || lr[37] !== 1'b0)
            begin errors++; $display("FAIL min0_ready_drop got r36=%b r37=%b want 1,0", lr[36], lr[37]); end
        f_end = 52;
        checks++; if (lr[f_end + 47] !== 1'b0 || lr[f_end + 48] !== 1'b1)
            begin errors++; $display("FAIL min0_ifg_ready got r=%b,%b want 0,1", lr[f_end + 47], lr[f_end + 48]); end
        bad = 0;
        for (int i = 0; i < lv.size(); i++) if (lv[i] !== 1'b1 && ld[i] !== 2'b00) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL min0_idle_zero got %0d nonzero idle dibits want 0", bad); end
    endtask

    task automatic test_pad_14();
        int s, n, bad;
        logic [31:0] f;
        clear_log();
        load_pattern(14, 3);
        send_frame(1, 300);
        find_run(0, s, n);
        checks++; if (s !== 1)   begin errors++; $display("FAIL pad_latency got start=%0d want 1", s); end
        checks++; if (n !== 256) begin errors++; $display("FAIL pad_length got %0d want 256", n); end
        bad = 0;
        for (int i = 0; i < 56; i++) if (ld[1 + i] !== body[i]) bad++;
        for (int i = 56; i < 240; i++) if (ld[1 + i] !== 2'b00) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL pad_body_zeros got %0d bad dibits want 0", bad); end
        get_fcs(241, f);
        checks++; if (f !== expected_fcs(60)) begin errors++; $display("FAIL pad_fcs got %h want %h", f, expected_fcs(60)); end
        checks++; if (lr[56] !== 1'b1 || lr[57] !== 1'b0)
            begin errors++; $display("FAIL pad_ready_drop got r56=%b r57=%b want 1,0", lr[56], lr[57]); end
        ref_v = lv;
        ref_d = ld;
    endtask

    task automatic test_nopad_64();
        int s, n, bad;
        logic [31:0] f;
        clear_log();
        load_pattern(64, 11);
        send_frame(1, 100);
        find_run(0, s, n);
        checks++; if (n !== 272) begin errors++; $display("FAIL nopad_length got %0d want 272", n); end
        bad = 0;
        for (int i = 0; i < 256; i++) if (ld[1 + i] !== body[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL nopad_echo got %0d bad dibits want 0", bad); end
        get_fcs(257, f);
        checks++; if (f !== expected_fcs(60)) begin errors++; $display("FAIL nopad_fcs got %h want %h", f, expected_fcs(60)); end
    endtask

    task automatic test_back_to_back();
        int s1, n1, s2, n2, sent2;
        logic low_seen;
        logic [31:0] f1, f2;
        clear_log();
        load_pattern(14, 5);
        for (int i = 0; i < 56; i++) cycle(1, 1'b1, body[i]);
        sent2 = 0;
        low_seen = 1'b0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk);
            #1;
            if (b_r === 1'b0) low_seen = 1'b1;
            if (low_seen && b_r === 1'b1 && sent2 < 56) begin
                b_v = 1'b1; b_d = body[sent2]; sent2++;
            end else begin
                b_v = 1'b0; b_d = 2'b00;
            end
            @(negedge clk);
            lv.push_back(b_ov); ld.push_back(b_od); lr.push_back(b_r);
        end
        checks++; if (sent2 !== 56) begin errors++; $display("FAIL b2b_ready_timeout got %0d dibits sent want 56", sent2); end
        find_run(0, s1, n1);
        find_run(s1 + n1, s2, n2);
        checks++; if (n1 !== 256 || n2 !== 256)
            begin errors++; $display("FAIL b2b_lengths got %0d,%0d want 256,256", n1, n2); end
        checks++; if (s2 - (s1 + n1) !== 48)
            begin errors++; $display("FAIL b2b_gap got %0d idle cycles want 48", s2 - (s1 + n1)); end
        get_fcs(s1 + 240, f1);
        get_fcs(s2 + 240, f2);
        checks++; if (f1 !== expected_fcs(60) || f2 !== expected_fcs(60))
            begin errors++; $display("FAIL b2b_fcs got %h,%h want %h", f1, f2, expected_fcs(60)); end
    endtask

    task automatic test_reset_fcs();
        int s, n;
        logic [31:0] f;
        clear_log();
        load_check_string();
        for (int i = 0; i < 36; i++) cycle(0, 1'b1, body[i]);
        for (int i = 0; i < 8; i++) cycle(0, 1'b0, 2'b00);
        checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL rstfcs_in_fcs got axiov=%b want 1", a_ov); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (a_ov !== 1'b0 || a_od !== 2'b00 || a_r !== 1'b1)
            begin errors++; $display("FAIL rstfcs_async got ov=%b od=%b r=%b want 0,00,1", a_ov, a_od, a_r); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        clear_log();
        send_frame(0, 80);
        find_run(0, s, n);
        checks++; if (s !== 1 || n !== 52) begin errors++; $display("FAIL rstfcs_rerun_run got start=%0d len=%0d want 1,52", s, n); end
        get_fcs(37, f);
        checks++; if (f !== 32'hCBF43926) begin errors++; $display("FAIL rstfcs_rerun_fcs got %h want cbf43926", f); end
    endtask

    task automatic test_violation();
        int bad;
        logic [31:0] f;
        clear_log();
        load_pattern(14, 3);
        for (int i = 0; i < 356; i++) begin
            if (i < 56) cycle(1, 1'b1, body[i]);
            else if (i inside {100, 101, 150, 245, 246, 270, 290}) cycle(1, 1'b1, 2'b11);
            else cycle(1, 1'b0, 2'b00);
        end
        bad = 0;
        for (int i = 0; i < 356; i++) if (lv[i] !== ref_v[i] || ld[i] !== ref_d[i]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL violation_stream got %0d differing cycles want 0", bad); end
        get_fcs(241, f);
        checks++; if (f !== expected_fcs(60)) begin errors++; $display("FAIL violation_fcs got %h want %h", f, expected_fcs(60)); end
        checks++; if (lr[100] !== 1'b0 || lr[270] !== 1'b0)
            begin errors++; $display("FAIL violation_ready got %b,%b want 0,0", lr[100], lr[270]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_crc_min0();
        test_pad_14();
        test_nopad_64();
        test_back_to_back();
        test_reset_fcs();
        test_violation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fcs_append.md
# fcs_append

Transmit-side Ethernet frame check sequence generator for the 2-bit RMII datapath. It accepts a frame body as a dibit stream: destination MAC through the end of the payload, with no preamble or SFD. It forwards the body with one cycle of latency and zero-pads it to the minimum frame length. It then appends the 32-bit CRC (FCS) as 16 dibits and enforces an interframe gap before accepting the next frame. Its output is intended to be checked bit-exactly by the receive-side checksum checker.

## Interface
Parameters:
- MIN_BYTES, default 60: minimum body length in bytes; shorter bodies are zero-padded. 0 disables padding.
- IFG_CYCLES, default 48: number of idle output cycles between frames (96 bit times).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately; deassertion must be synchronous to clk.
- axiiv  input  1  body dibit valid; a frame is one contiguous high run.
- axiid  input  2  body dibit; axiid[0] is the earlier bit on the wire.
- axiir  output  1  ready; axiiv may only rise in a cycle where axiir=1.
- axiov  output  1  output dibit valid; high for body, then pad, then FCS, with no gaps.
- axiod  output  2  output dibit, same bit order as axiid.

## Operation
- States are IDLE, DATA, PAD, FCS and IFG. The state register drives axiir directly: axiir=1 in IDLE and DATA, 0 otherwise. There is no combinational path from axiiv to axiir.
- CRC is Ethernet CRC-32, reflected polynomial 0xEDB88320.
  - The register is set to 0xFFFFFFFF in IDLE.
  - Per dibit, apply two serial steps, first bit axiid[0] then axiid[1]. One step: fb=crc[0]^b; crc=crc>>1; if fb, crc^=0xEDB88320.
- IDLE:
  - axiiv=1 → go to DATA. That dibit is forwarded and folded into the CRC.
  - axiiv=0 → stay in IDLE.
- DATA:
  - Each valid dibit is registered to the output and CRC-updated.
  - A byte counter saturates at MIN_BYTES and increments every 4 dibits.
  - The first cycle with axiiv=0 ends the frame. Go to PAD if bytes < MIN_BYTES, else FCS.
  - A body that is not a whole number of bytes is padded or appended from its dibit position. This is not an error.
- PAD:
  - Emit dibit 0 and CRC-update it.
  - Continue until the dibit count reaches 4*MIN_BYTES, then go to FCS.
- FCS:
  - fcs = ~crc, frozen at entry.
  - Emit dibit k = fcs[2k+1:2k] for k = 0..15, using a 4-bit counter. After k=15, go to IFG.
- IFG:
  - axiov=0; count IFG_CYCLES, then go to IDLE.
  - With IFG_CYCLES=0, go directly to IDLE.
- axiiv=1 while axiir=0 is a protocol violation. The input is ignored and has no effect on the output, the CRC or the state.
- When axiov=0, axiod is driven 0.

## Timing
- Reset values: axiov=0, axiod=0, axiir=1, state IDLE, crc=0xFFFFFFFF, all counters 0.
- Pass-through latency is 1 cycle: input dibit at cycle t appears on axiod at cycle t+1.
- If the last body dibit is at cycle t:
  - the first pad or FCS dibit appears at cycle t+2, so axiov stays continuous;
  - axiir=0 from cycle t+2.
- If the last FCS dibit is at cycle F:
  - axiov=0 for cycles F+1 .. F+IFG_CYCLES;
  - axiir=1 at cycle F+IFG_CYCLES;
  - the earliest next axiov=1 is F+IFG_CYCLES+1.
- Output length for an N-byte body: max(N, MIN_BYTES)*4 + 16 consecutive valid cycles.
- Reset asserted mid-frame in any state aborts the frame with no FCS. The next frame starts with a fresh CRC.

## Test plan
- MIN_BYTES=0, body "123456789" (36 dibits, each byte sent LSB-dibit first):
  - output echoes the body one cycle later;
  - FCS 0xCBF43926 follows as dibits 2,1,2,0,1,2,3,0,0,1,3,3,3,2,0,3;
  - axiov is high for exactly 52 cycles.
- Default parameters, 14-byte body:
  - 184 zero dibits follow, then the FCS; axiov is high for 256 consecutive cycles;
  - the receive checker fed this output reports done=1, kill=0.
- 64-byte body, default parameters:
  - no padding; axiov is high for 272 cycles;
  - the receive checker reports done=1, kill=0.
- Back-to-back frames, upstream raising axiiv as soon as axiir=1:
  - exactly 48 idle output cycles between frames;
  - both frames pass the receive checker.
- rst=0 during the FCS state:
  - axiov=0 and axiir=1 immediately, with no clk edge needed;
  - after release, a "123456789" frame again yields FCS 0xCBF43926.
- axiiv pulsed high during PAD, FCS and IFG:
  - output dibits and FCS are identical to an unperturbed run.
